mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter sitting on the core's data-memory bus beside the LED I/O register, consuming byte stores from the pipelined core and serialising them onto a Pmod pin. The core writes bytes into an 8-entry FIFO. An 8N1 serialiser drains the FIFO at a programmable baud divisor. Status is readable so firmware can poll for space before pushing.

---
 rtl/mmio_uart_tx.sv | 216 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter.
// The core pushes bytes through TXDATA into a small FIFO. An FSM drains the
// FIFO and serialises each byte at a baud divisor latched per frame, so a
// BAUDDIV write never disturbs the frame already on the wire.
module mmio_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sel,
  input  logic        mem_write,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic wr_en, wr_txdata, wr_status, wr_bauddiv;

  assign wr_en      = sel & mem_write;
  assign wr_txdata  = wr_en & (mem_addr[3:2] == REG_TXDATA);
  assign wr_status  = wr_en & (mem_addr[3:2] == REG_STATUS);
  assign wr_bauddiv = wr_en & (mem_addr[3:2] == REG_BAUDDIV);

  // Byte-lane bits and the upper data bits are not decoded by this block.
  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  // ---------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit to tell full from empty
  // ---------------------------------------------------------------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        empty, full, push, pop;
  logic [7:0]  pop_data;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // Full is the pre-edge value: a push while full is dropped even if the
  // serialiser pops in the same cycle.
  assign push     = wr_txdata & ~full;
  assign pop_data = fifo_mem[rptr_q[AW-1:0]];

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;

  // ---------------------------------------------------------------------
  // Serialiser state
  // ---------------------------------------------------------------------
  state_e      state_q;
  logic [7:0]  shift_q;
  logic [15:0] bitdiv_q;
  logic [15:0] cnt_q;
  logic [2:0]  bitcnt_q;
  logic        tx_q;
  logic        bit_end;
  logic        busy;

  assign bit_end = (cnt_q == 16'd0);
  assign busy    = (state_q != S_IDLE);

  // A new byte is taken either from idle or at the very end of a stop bit,
  // the latter giving gap-free back-to-back frames.
  assign pop = ~empty & ((state_q == S_IDLE) ||
                         ((state_q == S_STOP) && bit_end));

  // Next-state for FIFO pointers, overflow flag and baud divisor
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};

    ovf_d = ovf_q;
    if (wr_txdata && full)
      ovf_d = 1'b1;
    else if (wr_status && mem_wdata[3])
      ovf_d = 1'b0;

    div_d = div_q;
    if (wr_bauddiv)
      div_d = (mem_wdata[15:0] == 16'd0) ? 16'd1 : mem_wdata[15:0];
  end

  // Register the FIFO pointers and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      div_q  <= DEFAULT_DIV;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      div_q  <= div_d;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wptr_q[AW-1:0]] <= mem_wdata[7:0];
  end

  // 8N1 serialiser: every bit lasts bitdiv cycles, counted bitdiv-1 down to 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shift_q  <= 8'd0;
      bitdiv_q <= DEFAULT_DIV;
      cnt_q    <= 16'd0;
      bitcnt_q <= 3'd0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q  <= pop_data;
            bitdiv_q <= div_q;
            cnt_q    <= div_q - 16'd1;
            bitcnt_q <= 3'd0;
            tx_q     <= 1'b0;
            state_q  <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt_q   <= bitdiv_q - 16'd1;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt_q <= bitdiv_q - 16'd1;
            if (bitcnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              shift_q  <= {1'b0, shift_q[7:1]};
              tx_q     <= shift_q[1];
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              // Next byte already queued: straight into its start bit.
              shift_q  <= pop_data;
              bitdiv_q <= div_q;
              cnt_q    <= div_q - 16'd1;
              bitcnt_q <= 3'd0;
              tx_q     <= 1'b0;
              state_q  <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign irq_empty = empty & ~busy;

  // Combinational read mux; STATUS = {overflow, busy, empty, full}
  always_comb begin
    mem_rdata = 32'd0;
    case (mem_addr[3:2])
      REG_STATUS:  mem_rdata = {28'd0, ovf_q, busy, empty, full};
      REG_BAUDDIV: mem_rdata = {16'd0, div_q};
      default:     mem_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. The reference model describes each
// frame as the 10-symbol 8N1 sequence {stop, byte, start} sent LSB first,
// every symbol held for div cycles, and expects queued frames to abut.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_addr = 4'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        irq_empty;

  int nvec = 0;
  int nerr = 0;

  bit exp_bits[$];

  mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd104)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sel       (sel),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  // Reference model: append one 8N1 frame to the expected line waveform
  function automatic void add_frame(input logic [7:0] b, input int d);
    logic [9:0] sym;
    sym = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < d; k++)
        exp_bits.push_back(sym[i]);
  endfunction

  task automatic bus_write(input logic [1:0] ra, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; mem_write = 1'b1; mem_addr = {ra, 2'b00}; mem_wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] ra, output logic [31:0] d);
    sel = 1'b1; mem_write = 1'b0; mem_addr = {ra, 2'b00};
    #1;
    d = mem_rdata;
    sel = 1'b0;
  endtask

  // Follows the line from the first TXDATA capture and compares it bit-cycle
  // by bit-cycle with exp_bits, then checks the line stays idle for 'tail'.
  task automatic check_stream(input string name, input int tail);
    int errs;
    int lows;
    errs = 0;
    @(posedge clk iff (sel && mem_write && mem_addr[3:2] == 2'd0));
    @(negedge clk);
    nvec++;
    if (tx !== 1'b1) begin
      nerr++;
      $display("FAIL %s latency: tx=%b one edge after capture, required 1", name, tx);
    end
    foreach (exp_bits[i]) begin
      @(negedge clk);
      nvec++;
      if (tx !== exp_bits[i]) begin
        nerr++;
        errs++;
        if (errs <= 4)
          $display("FAIL %s bit cycle %0d: tx=%b required %b", name, i, tx, exp_bits[i]);
      end
    end
    @(negedge clk);
    nvec++;
    if (tx !== 1'b1 || irq_empty !== 1'b1) begin
      nerr++;
      $display("FAIL %s end: tx=%b irq_empty=%b required 1/1", name, tx, irq_empty);
    end
    lows = 0;
    repeat (tail) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    nvec++;
    if (lows != 0) begin
      nerr++;
      $display("FAIL %s tail: %0d non-idle cycles after stream, required 0", name, lows);
    end
    exp_bits.delete();
  endtask

  task automatic check_reg(input string name, input logic [1:0] ra, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(ra, d);
    nvec++;
    if (d !== exp) begin
      nerr++;
      $display("FAIL %s: read %08h required %08h", name, d, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #23;
    nvec++;
    if (tx !== 1'b1 || irq_empty !== 1'b1) begin
      nerr++;
      $display("FAIL reset outputs: tx=%b irq_empty=%b required 1/1", tx, irq_empty);
    end
    check_reg("reset status", 2'd1, 32'h2);
    check_reg("reset bauddiv", 2'd2, 32'd104);
    check_reg("reset txdata", 2'd0, 32'h0);
    check_reg("reset reserved", 2'd3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus_write(2'd2, 32'd4);
    add_frame(8'hA5, 4);
    fork
      check_stream("basic A5", 8);
      bus_write(2'd0, 32'hA5);
    join
    check_reg("basic status idle", 2'd1, 32'h2);
  endtask

  task automatic test_overflow();
    logic [7:0] pre;
    pre = 8'($urandom);
    bus_write(2'd2, 32'd104);
    add_frame(pre, 104);
    for (int i = 0; i < 8; i++) add_frame(8'(i), 104);
    fork
      check_stream("overflow stream", 40);
      begin
        bus_write(2'd0, {24'd0, pre});
        repeat (20) @(negedge clk);
        for (int i = 0; i < 9; i++) bus_write(2'd0, 32'(i));
        check_reg("overflow status", 2'd1, 32'hD);
      end
    join
    check_reg("overflow sticky", 2'd1, 32'hA);
    bus_write(2'd1, 32'h8);
    check_reg("overflow clear", 2'd1, 32'h2);
  endtask

  task automatic test_bauddiv_regs();
    logic [31:0] w;
    logic [15:0] lo;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      lo = w[15:0];
      bus_write(2'd2, w);
      check_reg("bauddiv readback", 2'd2, {16'd0, (lo == 16'd0) ? 16'd1 : lo});
    end
    bus_write(2'd3, $urandom);
    check_reg("reserved write ignored", 2'd2, {16'd0, (lo == 16'd0) ? 16'd1 : lo});
    check_reg("reserved read", 2'd3, 32'h0);
    check_reg("reserved no push", 2'd1, 32'h2);
    bus_write(2'd2, 32'hABCD_0000);
    check_reg("bauddiv zero", 2'd2, 32'd1);
    add_frame(8'hFF, 1);
    fork
      check_stream("div1 FF", 5);
      bus_write(2'd0, 32'hFF);
    join
  endtask

  task automatic test_back_to_back();
    bus_write(2'd2, 32'd2);
    add_frame(8'h55, 2);
    add_frame(8'h0F, 2);
    fork
      check_stream("b2b 55 0F", 6);
      begin
        bus_write(2'd0, 32'h55);
        bus_write(2'd0, 32'h0F);
      end
    join
  endtask

  task automatic test_div_midframe();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    bus_write(2'd2, 32'd4);
    add_frame(a, 4);
    add_frame(b, 8);
    fork
      check_stream("div midframe", 10);
      begin
        bus_write(2'd0, {24'd0, a});
        repeat (10) @(negedge clk);
        bus_write(2'd2, 32'd8);
        bus_write(2'd0, {24'd0, b});
      end
    join
    check_reg("div midframe readback", 2'd2, 32'd8);
  endtask

  task automatic test_random();
    int d, n;
    logic [7:0] bytes [4];
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(1, 6);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        bytes[i] = 8'($urandom);
        add_frame(bytes[i], d);
      end
      bus_write(2'd2, 32'(d));
      fork
        check_stream("random stream", 4);
        for (int i = 0; i < n; i++) bus_write(2'd0, {24'd0, bytes[i]});
      join
    end
  endtask

  task automatic test_reset_midframe();
    int lows;
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h00);
    bus_write(2'd0, 32'h3C);
    bus_write(2'd0, 32'h81);
    repeat (16) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if (tx !== 1'b1 || irq_empty !== 1'b1) begin
      nerr++;
      $display("FAIL midframe reset outputs: tx=%b irq_empty=%b required 1/1", tx, irq_empty);
    end
    check_reg("midframe reset status", 2'd1, 32'h2);
    @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    nvec++;
    if (lows != 0) begin
      nerr++;
      $display("FAIL after reset: %0d cycles with tx low, required 0", lows);
    end
    check_reg("after reset bauddiv", 2'd2, 32'd104);
    check_reg("after reset status", 2'd1, 32'h2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_bauddiv_regs();
    test_back_to_back();
    test_div_midframe();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
